// File: rtl/da2_pkg.sv
// rtl/da2_pkg.sv - shared types and constants for the Pmod DA2 driver
package da2_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } state_t;

   localparam int FRAME_BITS = 16;
   localparam int DATA_BITS  = 12;

   localparam logic [1:0] MODE_NORMAL = 2'b00;
   localparam logic [1:0] MODE_1K     = 2'b01;
   localparam logic [1:0] MODE_100K   = 2'b10;
   localparam logic [1:0] MODE_HIZ    = 2'b11;

   // DAC121S101 write word: two don't-care zeros, power-down bits, sample
   function automatic logic [FRAME_BITS-1:0] build_frame(
      input logic [1:0]           mode,
      input logic [DATA_BITS-1:0] data
   );
      return {2'b00, mode, data};
   endfunction

endpackage

// File: rtl/da2_sclk_gen.sv
// rtl/da2_sclk_gen.sv - SCLK half-period divider with edge strobes
module da2_sclk_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic run,
   output logic sclk,
   output logic fall_stb,
   output logic rise_stb
);

   localparam int CNT_W = $clog2(CLK_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sclk_q, sclk_d;
   logic             wrap;

   always_comb begin
      cnt_d  = cnt_q;
      sclk_d = sclk_q;
      wrap   = run && !clear && (cnt_q == CNT_LAST);
      if (clear) begin
         cnt_d  = '0;
         sclk_d = 1'b1;
      end else if (run) begin
         if (wrap) begin
            cnt_d  = '0;
            sclk_d = ~sclk_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q  <= '0;
         sclk_q <= 1'b1;
      end else begin
         cnt_q  <= cnt_d;
         sclk_q <= sclk_d;
      end
   end

   // strobes flag the cycle whose clock edge makes the SCLK transition
   assign sclk     = sclk_q;
   assign fall_stb = wrap &&  sclk_q;
   assign rise_stb = wrap && !sclk_q;

endmodule

// File: rtl/da2.sv
// rtl/da2.sv - Pmod DA2 driver: one write request yields one dual-channel DAC frame
module da2
   import da2_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        write,
   input  logic [11:0] data_a,
   input  logic [11:0] data_b,
   input  logic [1:0]  mode,
   output logic        SPI_SCLK,
   output logic        SYNC,
   output logic        DINA,
   output logic        DINB,
   output logic        busy,
   output logic        done
);

   localparam int GAP_W = $clog2(CLK_DIV);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CLK_DIV - 1);
   localparam logic [4:0]       BIT_LAST = 5'(FRAME_BITS);

   state_t                  state_q, state_d;
   logic [FRAME_BITS-1:0]   sh_a_q, sh_a_d;
   logic [FRAME_BITS-1:0]   sh_b_q, sh_b_d;
   logic [4:0]              bit_cnt_q, bit_cnt_d;
   logic [GAP_W-1:0]        gap_cnt_q, gap_cnt_d;

   logic sclk, fall_stb, rise_stb;
   logic in_shift;

   assign in_shift = (state_q == SHIFT);

   da2_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
      .clk      (clk),
      .rst      (rst),
      .clear    (!in_shift),
      .run      (in_shift),
      .sclk     (sclk),
      .fall_stb (fall_stb),
      .rise_stb (rise_stb)
   );

   always_comb begin
      state_d   = state_q;
      sh_a_d    = sh_a_q;
      sh_b_d    = sh_b_q;
      bit_cnt_d = bit_cnt_q;
      gap_cnt_d = gap_cnt_q;
      case (state_q)
         IDLE: begin
            if (write) begin
               state_d   = SHIFT;
               sh_a_d    = build_frame(mode, data_a);
               sh_b_d    = build_frame(mode, data_b);
               bit_cnt_d = '0;
            end
         end
         SHIFT: begin
            if (fall_stb) begin
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
            // the rise after the 16th fall closes the frame instead of shifting
            if (rise_stb) begin
               if (bit_cnt_q == BIT_LAST) begin
                  state_d   = GAP;
                  gap_cnt_d = '0;
                  sh_a_d    = '0;
                  sh_b_d    = '0;
               end else begin
                  sh_a_d = {sh_a_q[FRAME_BITS-2:0], 1'b0};
                  sh_b_d = {sh_b_q[FRAME_BITS-2:0], 1'b0};
               end
            end
         end
         GAP: begin
            if (gap_cnt_q == GAP_LAST) begin
               state_d = IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         sh_a_q    <= '0;
         sh_b_q    <= '0;
         bit_cnt_q <= '0;
         gap_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         sh_a_q    <= sh_a_d;
         sh_b_q    <= sh_b_d;
         bit_cnt_q <= bit_cnt_d;
         gap_cnt_q <= gap_cnt_d;
      end
   end

   assign SPI_SCLK = sclk;
   assign SYNC     = !in_shift;
   assign DINA     = in_shift && sh_a_q[FRAME_BITS-1];
   assign DINB     = in_shift && sh_b_q[FRAME_BITS-1];
   assign busy     = (state_q != IDLE);
   assign done     = (state_q == GAP) && (gap_cnt_q == GAP_LAST);

endmodule

// File: tb/tb_da2.sv
// tb/tb_da2.sv - directed, table-driven bench for the Pmod DA2 driver
module tb_da2;
   import da2_pkg::*;

   localparam int N    = 4;
   localparam int NONE = 100000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        write = 1'b0;
   logic [11:0] data_a = '0;
   logic [11:0] data_b = '0;
   logic [1:0]  mode = '0;
   logic        SPI_SCLK, SYNC, DINA, DINB, busy, done;

   da2 #(.CLK_DIV(N)) dut (
      .clk      (clk),
      .rst      (rst),
      .write    (write),
      .data_a   (data_a),
      .data_b   (data_b),
      .mode     (mode),
      .SPI_SCLK (SPI_SCLK),
      .SYNC     (SYNC),
      .DINA     (DINA),
      .DINB     (DINB),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   // SPI slave: clears at SYNC fall, shifts on SCLK falls while SYNC is low
   logic [15:0] cap_a = '0;
   logic [15:0] cap_b = '0;
   int          fall_cnt = 0;

   always @(negedge SPI_SCLK or negedge SYNC) begin
      if (SPI_SCLK === 1'b1) begin
         cap_a    <= '0;
         cap_b    <= '0;
         fall_cnt <= 0;
      end else if (SYNC === 1'b0) begin
         cap_a    <= {cap_a[14:0], DINA};
         cap_b    <= {cap_b[14:0], DINB};
         fall_cnt <= fall_cnt + 1;
      end
   end

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_sync"}, SYNC, 1);
      check({tag, "_sclk"}, SPI_SCLK, 1);
      check({tag, "_dina"}, DINA, 0);
      check({tag, "_dinb"}, DINB, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
   endtask

   int sync_lo, done_cnt, done_cyc, idle_cyc, nfalls, nr, min_hi;
   int rises[4];

   task automatic start(input logic [11:0] a, input logic [11:0] b, input logic [1:0] m);
      @(negedge clk);
      data_a = a;
      data_b = b;
      mode   = m;
      write  = 1'b1;
   endtask

   // cycle c is sampled at the falling clock edge after rising edge c-1
   task automatic run(input int ncyc, input int wr_until, input int pulse_at,
                      input int chg_at, input int rst_at);
      logic prev_sync;
      int   hi_run;
      sync_lo = 0; done_cnt = 0; done_cyc = 0; idle_cyc = 0;
      nfalls = 0; nr = 0; min_hi = 1000; hi_run = 0; prev_sync = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= ncyc; c++) begin
         @(negedge clk);
         if (c == wr_until) write = 1'b0;
         if (c == pulse_at) write = 1'b1;
         if (c == pulse_at + 1) write = 1'b0;
         if (c == chg_at) data_a = 12'h000;
         if (c == rst_at + 3) rst = 1'b1;
         if (c == rst_at) begin
            rst = 1'b0;
            #1;
            check_idle("midrst");
            check("midrst_partial_falls", fall_cnt, 7);
         end
         if (SYNC === 1'b0) sync_lo++;
         if (prev_sync === 1'b1 && SYNC === 1'b0) begin
            if (nfalls > 0 && hi_run < min_hi) min_hi = hi_run;
            nfalls++;
            hi_run = 0;
         end
         if (prev_sync === 1'b0 && SYNC === 1'b1 && nr < 4) begin
            rises[nr] = c;
            nr++;
         end
         if (SYNC === 1'b1) hi_run++;
         if (done === 1'b1) begin
            done_cnt++;
            done_cyc = c;
         end
         if (busy === 1'b0 && idle_cyc == 0) idle_cyc = c;
         prev_sync = SYNC;
      end
   endtask

   task automatic check_frame(input string tag, input logic [15:0] ea, input logic [15:0] eb);
      check({tag, "_cap_a"}, cap_a, ea);
      check({tag, "_cap_b"}, cap_b, eb);
      check({tag, "_falls"}, fall_cnt, 16);
      check({tag, "_sync_low"}, sync_lo, 128);
      check({tag, "_done_cyc"}, done_cyc, 132);
      check({tag, "_done_cnt"}, done_cnt, 1);
      check({tag, "_idle_cyc"}, idle_cyc, 133);
      check({tag, "_sync_rise"}, rises[0], 129);
   endtask

   typedef struct {
      logic [11:0] a;
      logic [11:0] b;
      logic [1:0]  m;
      logic [15:0] ea;
      logic [15:0] eb;
   } vec_t;

   vec_t vecs[4];

   initial begin
      vecs[0] = '{12'hA5C, 12'h3F1, MODE_NORMAL, 16'h0A5C, 16'h03F1};
      vecs[1] = '{12'hFFF, 12'h000, MODE_HIZ,    16'h3FFF, 16'h3000};
      vecs[2] = '{12'h123, 12'h800, MODE_1K,     16'h1123, 16'h1800};
      vecs[3] = '{12'h000, 12'hFFF, MODE_100K,   16'h2000, 16'h2FFF};

      repeat (3) begin
         @(negedge clk);
         check_idle("in_reset");
      end
      rst = 1'b1;
      repeat (8) begin
         @(negedge clk);
         check_idle("after_reset");
      end

      for (int i = 0; i < 4; i++) begin
         start(vecs[i].a, vecs[i].b, vecs[i].m);
         run(140, 1, NONE, NONE, NONE);
         check_frame($sformatf("vec%0d", i), vecs[i].ea, vecs[i].eb);
      end

      start(12'h5A5, 12'h0F0, MODE_NORMAL);
      run(300, 1, 40, 10, NONE);
      check("busy_cap_a", cap_a, 16'h05A5);
      check("busy_cap_b", cap_b, 16'h00F0);
      check("busy_frames", nfalls, 1);
      check("busy_sync_low", sync_lo, 128);
      check("busy_falls", fall_cnt, 16);

      start(12'h7E1, 12'h01E, MODE_1K);
      run(420, 300, NONE, NONE, NONE);
      check("held_frames", nfalls, 3);
      check("held_rise0", rises[0], 129);
      check("held_rise1", rises[1], 262);
      check("held_rise2", rises[2], 395);
      check("held_min_high", min_hi, 5);
      check("held_sync_low", sync_lo, 384);
      check("held_done_cnt", done_cnt, 3);
      check("held_cap_a", cap_a, 16'h17E1);
      check("held_cap_b", cap_b, 16'h101E);

      start(12'h456, 12'h789, MODE_100K);
      run(80, 1, NONE, NONE, 60);
      check_idle("post_midrst");
      start(12'h123, 12'h321, MODE_NORMAL);
      run(140, 1, NONE, NONE, NONE);
      check_frame("fresh", 16'h0123, 16'h0321);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
